// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, req/ack instruction fetch and the IF/ID register.
// A one-entry buffer keeps a fetch that completes while decode is stalled.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] if_pc
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_id_pc4;
  logic [31:0] r_id_inst;
  logic        r_id_valid;

  logic        w_have_inst;
  logic        w_capture;
  logic        w_advance;
  logic        w_bubble;
  logic [31:0] w_inst_src;
  logic [31:0] w_pc4;
  logic [31:0] w_next_pc;
  logic [1:0]  w_sel;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_have_inst  = 1'b0;
    w_inst_src   = r_buf;
    w_capture    = 1'b0;
    case (r_state)
      FETCH: begin
        w_have_inst = imem_ack;
        w_inst_src  = imem_rdata;
        if (imem_ack && stall) begin
          w_state_next = HOLD;
          w_capture    = 1'b1;
        end
      end
      HOLD: begin
        w_have_inst = 1'b1;
        if (!stall) w_state_next = FETCH;
      end
    endcase
  end

  assign w_advance = w_have_inst && !stall;
  assign w_bubble  = !w_have_inst && !stall;
  assign w_pc4     = r_pc + 32'd4;

  // A redirect only counts when decode holds a real instruction; it lands after the delay slot.
  assign w_sel = r_id_valid ? pcsource : 2'b00;

  always_comb begin
    w_next_pc = w_pc4;
    case (w_sel)
      2'b01:   w_next_pc = bpc;
      2'b10:   w_next_pc = rpc;
      2'b11:   w_next_pc = jpc;
      default: w_next_pc = w_pc4;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_pc       <= RESET_PC;
      r_buf      <= 32'd0;
      r_id_pc4   <= 32'd0;
      r_id_inst  <= 32'd0;
      r_id_valid <= 1'b0;
    end else begin
      if (w_capture) r_buf <= imem_rdata;
      if (w_advance) begin
        r_id_pc4   <= w_pc4;
        r_id_inst  <= w_inst_src;
        r_id_valid <= 1'b1;
        r_pc       <= w_next_pc;
      end else if (w_bubble) begin
        r_id_inst  <= 32'd0;
        r_id_valid <= 1'b0;
      end
    end
  end

  assign imem_req  = (r_state == FETCH) && !clr;
  assign imem_addr = r_pc;
  assign if_pc     = r_pc;
  assign id_pc4    = r_id_pc4;
  assign id_inst   = r_id_inst;
  assign id_valid  = r_id_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a table of zero-wait vectors plus hand-written
// sequences for stall, slow memory, mid-cycle clear and PC wrap, all backed by a scoreboard.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = 32'd0;
  logic [31:0] jpc = 32'd0;
  logic [31:0] rpc = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] id_pc4;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] if_pc;

  if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid),
    .if_pc(if_pc)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;

  // Memory model: ack once the request has been up for memCycles cycles, data = address
  int memCycles = 1;
  int reqCount = 0;

  // Reference model of the fetch stage and the scoreboard of expected IF/ID contents
  logic [31:0] expPc;
  logic [31:0] expPc4;
  logic [31:0] expInst;
  logic        expValid;
  logic        held;
  logic [31:0] heldInst;
  logic        pushed;
  logic [63:0] sbQ[$];

  typedef struct {
    logic        st;
    logic [1:0]  ps;
    logic [31:0] expAddr;
    logic        expReq;
    logic        expValid;
    logic [31:0] expInst;
    logic [31:0] expPc4;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] slowAddr[6];
  logic        slowValid[6];
  logic [31:0] slowInst[6];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      passCount++;
  endtask

  // Clear the reference model after a reset of the DUT
  task automatic resetModel();
    expPc    = RESET_PC;
    expPc4   = 32'd0;
    expInst  = 32'd0;
    expValid = 1'b0;
    held     = 1'b0;
    heldInst = 32'd0;
    pushed   = 1'b0;
    reqCount = 0;
    sbQ.delete();
  endtask

  // Compare every observable output against the model, popping the scoreboard on a delivery
  task automatic checkOutput();
    logic [63:0] item;
    if (pushed) begin
      if (sbQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL sb_empty: got empty queue expected an entry at %0t", $time);
      end else begin
        item     = sbQ.pop_front();
        expPc4   = item[63:32];
        expInst  = item[31:0];
        expValid = 1'b1;
      end
    end
    checkVal("id_valid", {31'b0, id_valid}, {31'b0, expValid});
    checkVal("id_pc4", id_pc4, expPc4);
    checkVal("id_inst", id_inst, expInst);
    checkVal("imem_addr", imem_addr, expPc);
    checkVal("if_pc", if_pc, expPc);
    checkVal("imem_req", {31'b0, imem_req}, {31'b0, !held});
  endtask

  // Drive one cycle of stimulus (entered just after a falling edge), clock it, then check
  task automatic applyStimulus(input logic st, input logic [1:0] ps);
    logic [31:0] instSrc;
    logic [31:0] nextPc4;
    logic [1:0]  sel;
    stall      = st;
    pcsource   = ps;
    imem_ack   = 1'b0;
    imem_rdata = 32'hBAAD_F00D;
    if (imem_req) begin
      reqCount++;
      if (reqCount >= memCycles) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr;
        reqCount   = 0;
      end
    end
    pushed = 1'b0;
    if ((imem_ack || held) && !st) begin
      instSrc = held ? heldInst : imem_rdata;
      nextPc4 = expPc + 32'd4;
      sbQ.push_back({nextPc4, instSrc});
      sel = expValid ? ps : 2'b00;
      case (sel)
        2'b01:   expPc = bpc;
        2'b10:   expPc = rpc;
        2'b11:   expPc = jpc;
        default: expPc = nextPc4;
      endcase
      held   = 1'b0;
      pushed = 1'b1;
    end else if (!st) begin
      expValid = 1'b0;
      expInst  = 32'd0;
    end else if (imem_ack && !held) begin
      held     = 1'b1;
      heldInst = imem_rdata;
    end
    @(posedge clk);
    #1 imem_ack = 1'b0;
    @(negedge clk);
    checkOutput();
  endtask

  // Hold clear across a rising edge, check reset values, release near a falling edge
  task automatic doReset();
    clr        = 1'b1;
    stall      = 1'b0;
    pcsource   = 2'b00;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    #1;
    checkVal("req_in_reset", {31'b0, imem_req}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkVal("rst_id_valid", {31'b0, id_valid}, 32'd0);
    checkVal("rst_id_pc4", id_pc4, 32'd0);
    checkVal("rst_id_inst", id_inst, 32'd0);
    checkVal("rst_if_pc", if_pc, RESET_PC);
    clr = 1'b0;
    resetModel();
    #1;
    checkVal("first_req", {31'b0, imem_req}, 32'd1);
    checkVal("first_addr", imem_addr, RESET_PC);
  endtask

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Zero-wait stream with branch/jr/jump redirects and one stall, bpc=0x100 rpc=0x200 jpc=0x300
    vecs[0]  = '{1'b0, 2'b00, 32'h004, 1'b1, 1'b1, 32'h000, 32'h004};
    vecs[1]  = '{1'b0, 2'b00, 32'h008, 1'b1, 1'b1, 32'h004, 32'h008};
    vecs[2]  = '{1'b0, 2'b00, 32'h00C, 1'b1, 1'b1, 32'h008, 32'h00C};
    vecs[3]  = '{1'b0, 2'b01, 32'h100, 1'b1, 1'b1, 32'h00C, 32'h010};
    vecs[4]  = '{1'b0, 2'b00, 32'h104, 1'b1, 1'b1, 32'h100, 32'h104};
    vecs[5]  = '{1'b0, 2'b10, 32'h200, 1'b1, 1'b1, 32'h104, 32'h108};
    vecs[6]  = '{1'b0, 2'b00, 32'h204, 1'b1, 1'b1, 32'h200, 32'h204};
    vecs[7]  = '{1'b0, 2'b11, 32'h300, 1'b1, 1'b1, 32'h204, 32'h208};
    vecs[8]  = '{1'b0, 2'b00, 32'h304, 1'b1, 1'b1, 32'h300, 32'h304};
    vecs[9]  = '{1'b1, 2'b00, 32'h304, 1'b0, 1'b1, 32'h300, 32'h304};
    vecs[10] = '{1'b0, 2'b00, 32'h308, 1'b1, 1'b1, 32'h304, 32'h308};
    vecs[11] = '{1'b0, 2'b00, 32'h30C, 1'b1, 1'b1, 32'h308, 32'h30C};

    // Two-cycle memory with pcsource=01 held throughout: one bubble per instruction, no redirect
    slowAddr[0] = 32'h0; slowValid[0] = 1'b0; slowInst[0] = 32'h0;
    slowAddr[1] = 32'h4; slowValid[1] = 1'b1; slowInst[1] = 32'h0;
    slowAddr[2] = 32'h4; slowValid[2] = 1'b0; slowInst[2] = 32'h0;
    slowAddr[3] = 32'h8; slowValid[3] = 1'b1; slowInst[3] = 32'h4;
    slowAddr[4] = 32'h8; slowValid[4] = 1'b0; slowInst[4] = 32'h0;
    slowAddr[5] = 32'hC; slowValid[5] = 1'b1; slowInst[5] = 32'h8;

    bpc = 32'h100;
    rpc = 32'h200;
    jpc = 32'h300;
    memCycles = 1;
    #2;
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].st, vecs[i].ps);
      checkVal($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
      checkVal($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      checkVal($sformatf("vec%0d_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].expValid});
      checkVal($sformatf("vec%0d_inst", i), id_inst, vecs[i].expInst);
      checkVal($sformatf("vec%0d_pc4", i), id_pc4, vecs[i].expPc4);
    end

    // Stall for three cycles across the ack at 0x8
    doReset();
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00);
    checkVal("stall_req_low", {31'b0, imem_req}, 32'd0);
    checkVal("stall_inst_held", id_inst, 32'h4);
    checkVal("stall_pc4_held", id_pc4, 32'h8);
    applyStimulus(1'b0, 2'b00);
    checkVal("release_inst", id_inst, 32'h8);
    checkVal("release_addr", imem_addr, 32'hC);
    applyStimulus(1'b0, 2'b00);
    checkVal("after_release_inst", id_inst, 32'hC);

    // Two-cycle memory, redirect ignored while ID holds a bubble
    memCycles = 2;
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 2'b01);
      checkVal($sformatf("slow%0d_addr", i), imem_addr, slowAddr[i]);
      checkVal($sformatf("slow%0d_valid", i), {31'b0, id_valid}, {31'b0, slowValid[i]});
      checkVal($sformatf("slow%0d_inst", i), id_inst, slowInst[i]);
    end

    // Clear pulsed mid-cycle with a request pending; the ack during clear must be dropped
    #1 clr = 1'b1;
    #1;
    checkVal("clr_req", {31'b0, imem_req}, 32'd0);
    checkVal("clr_valid", {31'b0, id_valid}, 32'd0);
    checkVal("clr_inst", id_inst, 32'd0);
    checkVal("clr_pc4", id_pc4, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    checkVal("clr_ack_valid", {31'b0, id_valid}, 32'd0);
    checkVal("clr_ack_inst", id_inst, 32'd0);
    checkVal("clr_ack_pc", if_pc, RESET_PC);
    imem_ack = 1'b0;
    #1 clr = 1'b0;
    resetModel();
    #1;
    checkVal("post_clr_addr", imem_addr, 32'd0);
    checkVal("post_clr_req", {31'b0, imem_req}, 32'd1);
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b00);

    // jr to the top of the address space; pc+4 wraps to zero
    memCycles = 1;
    rpc = 32'hFFFF_FFFC;
    doReset();
    applyStimulus(1'b0, 2'b00);
    applyStimulus(1'b0, 2'b10);
    checkVal("wrap_target", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 2'b00);
    checkVal("wrap_pc4", id_pc4, 32'd0);
    checkVal("wrap_inst", id_inst, 32'hFFFF_FFFC);
    checkVal("wrap_addr", imem_addr, 32'd0);
    applyStimulus(1'b0, 2'b00);

    checkVal("sb_drained", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
